// File: rtl/dvi_start_seq.sv
// Start-up and recovery sequencer for the DVI output path: holds dvi_top in reset
// until PLL lock is stable, blanks video for whole frames, and records lock losses.
module dvi_start_seq #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int BLANK_FRAMES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_lock_i,
  input  logic       frame_start_i,
  input  logic       lock_err_clr_i,
  output logic       dvi_rst_o,
  output logic       video_en_o,
  output logic [1:0] state_o,
  output logic       lock_lost_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_BLANK     = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam int FRM_W = $clog2(BLANK_FRAMES + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_ZERO = CNT_W'(0);
  localparam logic [FRM_W-1:0] FRAME_LAST  = FRM_W'(BLANK_FRAMES - 1);
  localparam logic [FRM_W-1:0] FRAME_ONE   = FRM_W'(1);
  localparam logic [FRM_W-1:0] FRAME_ZERO  = FRM_W'(0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [CNT_W-1:0]       stable_cnt_r;
  logic [CNT_W-1:0]       stable_cnt_nxt_s;
  logic [FRM_W-1:0]       frame_cnt_r;
  logic [FRM_W-1:0]       frame_cnt_nxt_s;
  logic                   loss_evt_s;
  logic                   lock_lost_r;
  logic [7:0]             loss_cnt_r;
  logic                   dvi_rst_r;
  logic                   video_en_r;

  assign lock_s = sync_r[SYNC_STAGES-1];

  // Synchronize the asynchronous PLL lock into the pixel clock domain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  // Sequencer next-state and counter logic; a lock drop outranks a frame pulse
  always_comb begin
    state_nxt_s      = state_r;
    stable_cnt_nxt_s = stable_cnt_r;
    frame_cnt_nxt_s  = frame_cnt_r;
    loss_evt_s       = 1'b0;
    case (state_r)
      ST_WAIT_LOCK: begin
        stable_cnt_nxt_s = STABLE_ZERO;
        if (lock_s) begin
          state_nxt_s = ST_STABLE;
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        // Losing lock before reset release is not a loss event.
        if (!lock_s) begin
          state_nxt_s      = ST_WAIT_LOCK;
          stable_cnt_nxt_s = STABLE_ZERO;
        end else if (stable_cnt_r == STABLE_LAST) begin
          state_nxt_s     = ST_BLANK;
          frame_cnt_nxt_s = FRAME_ZERO;
        end else begin
          stable_cnt_nxt_s = stable_cnt_r + STABLE_ONE;
        end
      end
      ST_BLANK: begin
        if (!lock_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          loss_evt_s  = 1'b1;
        end else if (frame_start_i) begin
          frame_cnt_nxt_s = frame_cnt_r + FRAME_ONE;
          if (frame_cnt_r == FRAME_LAST) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_BLANK;
          end
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          loss_evt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_LOCK;
      end
    endcase
  end

  // State, counters, and outputs registered from the next state so they track state_r exactly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_WAIT_LOCK;
      stable_cnt_r <= STABLE_ZERO;
      frame_cnt_r  <= FRAME_ZERO;
      dvi_rst_r    <= 1'b1;
      video_en_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      stable_cnt_r <= stable_cnt_nxt_s;
      frame_cnt_r  <= frame_cnt_nxt_s;
      dvi_rst_r    <= (state_nxt_s == ST_WAIT_LOCK) || (state_nxt_s == ST_STABLE);
      video_en_r   <= (state_nxt_s == ST_RUN);
    end
  end

  // Sticky loss flag (set wins over clear) and saturating loss counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_lost_r <= 1'b0;
      loss_cnt_r  <= 8'd0;
    end else begin
      if (loss_evt_s) begin
        lock_lost_r <= 1'b1;
      end else if (lock_err_clr_i) begin
        lock_lost_r <= 1'b0;
      end else begin
        lock_lost_r <= lock_lost_r;
      end
      if (loss_evt_s && (loss_cnt_r != 8'hFF)) begin
        loss_cnt_r <= loss_cnt_r + 8'd1;
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
    end
  end

  assign dvi_rst_o       = dvi_rst_r;
  assign video_en_o      = video_en_r;
  assign state_o         = state_r;
  assign lock_lost_o     = lock_lost_r;
  assign lock_loss_cnt_o = loss_cnt_r;

endmodule
